control_fsm: RTL and testbench

//  Multi-cycle control unit driving the datapath control inputs from the fetched Instr and the ALU Zero flag.
//  One FSM sequences each instruction: decode, execute, memory, writeback/PC update.

---
 rtl/control_fsm.sv | 231 +++++++++++++++++++++++
 tb/tb_control_fsm.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/control_fsm.sv
// Multi-cycle control unit. One FSM walks every instruction through decode,
// execute, memory and writeback/PC update, and drives the datapath control
// inputs from the registered state, the current Instr and the ALU Zero flag.
//
// Parameters:
//   TRAP_ON_ILLEGAL  1: an illegal opcode/func parks in the illegal state with
//                    Halt=1 until reset; 0: the instruction retires as a NOP.
//
// Ports:
//   Clk            in   system clock, all state changes on posedge
//   Reset_n        in   asynchronous active-low reset
//   Instr[31:0]    in   current instruction from the fetch stage
//   Zero           in   ALU result == 0, consulted only while branching
//   PC_sel         out  0: PC+4, 1: PC+4+Immed
//   PC_LdEn        out  load PC, ends the instruction
//   RF_WrData_sel  out  0: ALU_out, 1: MEM_out
//   RF_B_sel       out  0: rt=Instr[15:11], 1: rd=Instr[20:16]
//   RF_WrEn        out  register file write enable
//   ALU_Bin_sel    out  0: RF_B, 1: Immed
//   ALU_func[3:0]  out  ALU operation select
//   MEM_WrEn       out  data memory write enable
//   Instr_done     out  retire pulse, identical to PC_LdEn
//   Halt           out  high only while trapped on an illegal instruction
module control_fsm #(
  parameter bit TRAP_ON_ILLEGAL = 1'b0
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [31:0] Instr,
  input  logic        Zero,
  output logic        PC_sel,
  output logic        PC_LdEn,
  output logic        RF_WrData_sel,
  output logic        RF_B_sel,
  output logic        RF_WrEn,
  output logic        ALU_Bin_sel,
  output logic [3:0]  ALU_func,
  output logic        MEM_WrEn,
  output logic        Instr_done,
  output logic        Halt
);

  // Opcodes (Instr[31:26])
  localparam logic [5:0] OpR    = 6'b100000;
  localparam logic [5:0] OpLi   = 6'b111000;
  localparam logic [5:0] OpLui  = 6'b111001;
  localparam logic [5:0] OpAddi = 6'b110000;
  localparam logic [5:0] OpAndi = 6'b110010;
  localparam logic [5:0] OpOri  = 6'b110011;
  localparam logic [5:0] OpB    = 6'b111111;
  localparam logic [5:0] OpBeq  = 6'b000000;
  localparam logic [5:0] OpBne  = 6'b000001;
  localparam logic [5:0] OpLb   = 6'b000011;
  localparam logic [5:0] OpLw   = 6'b001111;
  localparam logic [5:0] OpSb   = 6'b000111;
  localparam logic [5:0] OpSw   = 6'b011111;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0001;
  localparam logic [3:0] AluAnd = 4'b0010;
  localparam logic [3:0] AluOr  = 4'b0011;

  typedef enum logic [3:0] {
    StReset,
    StDecode,
    StAlu,
    StWbAlu,
    StAddr,
    StMemRd,
    StWbMem,
    StMemWr,
    StBr,
    StIll
  } state_e;

  state_e state_q;

  logic [5:0] opcode;
  logic [5:0] func;
  logic       is_r;
  logic       r_func_ok;
  logic       is_ialu;
  logic       is_load;
  logic       is_store;
  logic       is_br;
  logic [3:0] op_alu_func;
  logic       op_alu_bin;
  logic       br_taken;

  assign opcode = Instr[31:26];
  assign func   = Instr[5:0];

  // Only opcode, func and the low func bits steer control; the rest is datapath.
  logic unused_instr;
  assign unused_instr = ^Instr[25:6];

  // Instruction classification
  always_comb begin
    is_r      = (opcode == OpR);
    is_ialu   = (opcode == OpLi) || (opcode == OpLui) || (opcode == OpAddi) ||
                (opcode == OpAndi) || (opcode == OpOri);
    is_load   = (opcode == OpLb) || (opcode == OpLw);
    is_store  = (opcode == OpSb) || (opcode == OpSw);
    is_br     = (opcode == OpB) || (opcode == OpBeq) || (opcode == OpBne);
    r_func_ok = 1'b0;
    case (func)
      6'b110000, 6'b110001, 6'b110010, 6'b110011, 6'b110100,
      6'b111000, 6'b111001, 6'b111010, 6'b111100, 6'b111101: r_func_ok = 1'b1;
      default:                                               r_func_ok = 1'b0;
    endcase
  end

  // ALU controls for R/I-type ops; held in both execute and writeback since the
  // datapath has no pipeline registers between ALU and register file.
  always_comb begin
    op_alu_func = AluAdd;
    op_alu_bin  = 1'b0;
    if (is_r) begin
      op_alu_func = Instr[3:0];
    end else begin
      op_alu_bin = 1'b1;
      case (opcode)
        OpAndi:  op_alu_func = AluAnd;
        OpOri:   op_alu_func = AluOr;
        default: op_alu_func = AluAdd;
      endcase
    end
  end

  // Branch decision: b always taken, beq on Zero, bne on !Zero
  always_comb begin
    case (opcode)
      OpBeq:   br_taken = Zero;
      OpBne:   br_taken = ~Zero;
      default: br_taken = 1'b1;
    endcase
  end

  // State register and transitions
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StReset;
    end else begin
      unique case (state_q)
        StReset:  state_q <= StDecode;
        StDecode: begin
          if ((is_r && r_func_ok) || is_ialu) begin
            state_q <= StAlu;
          end else if (is_load || is_store) begin
            state_q <= StAddr;
          end else if (is_br) begin
            state_q <= StBr;
          end else begin
            state_q <= StIll;
          end
        end
        StAlu:    state_q <= StWbAlu;
        StWbAlu:  state_q <= StDecode;
        StAddr:   state_q <= is_load ? StMemRd : StMemWr;
        StMemRd:  state_q <= StWbMem;
        StWbMem:  state_q <= StDecode;
        StMemWr:  state_q <= StDecode;
        StBr:     state_q <= StDecode;
        StIll:    state_q <= TRAP_ON_ILLEGAL ? StIll : StDecode;
        default:  state_q <= StReset;
      endcase
    end
  end

  // Outputs decoded from state; anything not set for a state stays 0.
  always_comb begin
    PC_sel        = 1'b0;
    PC_LdEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    RF_B_sel      = 1'b0;
    RF_WrEn       = 1'b0;
    ALU_Bin_sel   = 1'b0;
    ALU_func      = AluAdd;
    MEM_WrEn      = 1'b0;
    Halt          = 1'b0;
    unique case (state_q)
      StReset, StDecode: ;
      StAlu: begin
        ALU_func    = op_alu_func;
        ALU_Bin_sel = op_alu_bin;
      end
      StWbAlu: begin
        ALU_func    = op_alu_func;
        ALU_Bin_sel = op_alu_bin;
        RF_WrEn     = 1'b1;
        PC_LdEn     = 1'b1;
      end
      // Address = base + Immed, held through every memory-phase state
      StAddr, StMemRd: begin
        ALU_func    = AluAdd;
        ALU_Bin_sel = 1'b1;
      end
      StWbMem: begin
        ALU_func      = AluAdd;
        ALU_Bin_sel   = 1'b1;
        RF_WrEn       = 1'b1;
        RF_WrData_sel = 1'b1;
        PC_LdEn       = 1'b1;
      end
      StMemWr: begin
        ALU_func    = AluAdd;
        ALU_Bin_sel = 1'b1;
        RF_B_sel    = 1'b1;
        MEM_WrEn    = 1'b1;
        PC_LdEn     = 1'b1;
      end
      StBr: begin
        ALU_func = AluSub;
        RF_B_sel = 1'b1;
        PC_LdEn  = 1'b1;
        PC_sel   = br_taken;
      end
      StIll: begin
        if (TRAP_ON_ILLEGAL) begin
          Halt = 1'b1;
        end else begin
          PC_LdEn = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign Instr_done = PC_LdEn;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: one instance without trap and one with trap,
// driven in lockstep. Outputs are packed as
// {PC_sel, PC_LdEn, RF_WrData_sel, RF_B_sel, RF_WrEn, ALU_Bin_sel, ALU_func,
//  MEM_WrEn, Instr_done, Halt}.
module tb_control_fsm;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [31:0] Instr;
  logic        Zero;

  logic        pcs0, ld0, wds0, bs0, wr0, bin0, mw0, dn0, h0;
  logic        pcs1, ld1, wds1, bs1, wr1, bin1, mw1, dn1, h1;
  logic [3:0]  fn0, fn1;
  logic [12:0] obs0, obs1;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  control_fsm #(.TRAP_ON_ILLEGAL(1'b0)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .Instr(Instr), .Zero(Zero),
    .PC_sel(pcs0), .PC_LdEn(ld0), .RF_WrData_sel(wds0), .RF_B_sel(bs0),
    .RF_WrEn(wr0), .ALU_Bin_sel(bin0), .ALU_func(fn0), .MEM_WrEn(mw0),
    .Instr_done(dn0), .Halt(h0)
  );

  control_fsm #(.TRAP_ON_ILLEGAL(1'b1)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .Instr(Instr), .Zero(Zero),
    .PC_sel(pcs1), .PC_LdEn(ld1), .RF_WrData_sel(wds1), .RF_B_sel(bs1),
    .RF_WrEn(wr1), .ALU_Bin_sel(bin1), .ALU_func(fn1), .MEM_WrEn(mw1),
    .Instr_done(dn1), .Halt(h1)
  );

  assign obs0 = {pcs0, ld0, wds0, bs0, wr0, bin0, fn0, mw0, dn0, h0};
  assign obs1 = {pcs1, ld1, wds1, bs1, wr1, bin1, fn1, mw1, dn1, h1};

  // Expected-vector packer; the retire pulse is passed in explicitly.
  function automatic logic [12:0] ev(bit pcs, bit ld, bit wds, bit bs, bit wr, bit bin,
                                     logic [3:0] fn, bit mw, bit dn, bit h);
    return {pcs, ld, wds, bs, wr, bin, fn, mw, dn, h};
  endfunction

  function automatic logic [31:0] op_instr(logic [5:0] op);
    return {op, 26'h2A55A5};
  endfunction

  function automatic logic [31:0] r_instr(logic [5:0] fn);
    return {6'b100000, 20'hB3C1D, fn};
  endfunction

  task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Enter with both DUTs in decode at posedge+1; leave the same way.
  task automatic run(input string tag, input logic [31:0] ins, input logic z, input int n,
                     input logic [12:0] e2, input logic [12:0] e3, input logic [12:0] e4);
    logic [12:0] e;
    Instr = ins;
    Zero  = z;
    #1;
    check($sformatf("%s_c1_d0", tag), obs0, 13'h0);
    check($sformatf("%s_c1_d1", tag), obs1, 13'h0);
    for (int k = 2; k <= n; k++) begin
      @(posedge Clk); #1;
      e = (k == 2) ? e2 : ((k == 3) ? e3 : e4);
      check($sformatf("%s_c%0d_d0", tag, k), obs0, e);
      check($sformatf("%s_c%0d_d1", tag, k), obs1, e);
    end
    @(posedge Clk); #1;
  endtask

  localparam logic [12:0] Zv = 13'h0;

  initial begin
    logic [12:0] alu_add, wb_add, alu_sub, wb_sub, alu_sra, wb_sra;
    logic [12:0] alu_ori, wb_ori, alu_andi, wb_andi, alu_lui, wb_lui;
    logic [12:0] addr, wb_mem, mem_wr, br_t, br_nt;

    alu_add  = ev(0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
    wb_add   = ev(0, 1, 0, 0, 1, 0, 4'b0000, 0, 1, 0);
    alu_sub  = ev(0, 0, 0, 0, 0, 0, 4'b0001, 0, 0, 0);
    wb_sub   = ev(0, 1, 0, 0, 1, 0, 4'b0001, 0, 1, 0);
    alu_sra  = ev(0, 0, 0, 0, 0, 0, 4'b1000, 0, 0, 0);
    wb_sra   = ev(0, 1, 0, 0, 1, 0, 4'b1000, 0, 1, 0);
    alu_ori  = ev(0, 0, 0, 0, 0, 1, 4'b0011, 0, 0, 0);
    wb_ori   = ev(0, 1, 0, 0, 1, 1, 4'b0011, 0, 1, 0);
    alu_andi = ev(0, 0, 0, 0, 0, 1, 4'b0010, 0, 0, 0);
    wb_andi  = ev(0, 1, 0, 0, 1, 1, 4'b0010, 0, 1, 0);
    alu_lui  = ev(0, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0);
    wb_lui   = ev(0, 1, 0, 0, 1, 1, 4'b0000, 0, 1, 0);
    addr     = ev(0, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0);
    wb_mem   = ev(0, 1, 1, 0, 1, 1, 4'b0000, 0, 1, 0);
    mem_wr   = ev(0, 1, 0, 1, 0, 1, 4'b0000, 1, 1, 0);
    br_t     = ev(1, 1, 0, 1, 0, 0, 4'b0001, 0, 1, 0);
    br_nt    = ev(0, 1, 0, 1, 0, 0, 4'b0001, 0, 1, 0);

    // Reset and the reset -> decode step
    Reset_n = 1'b0;
    Instr   = r_instr(6'b110000);
    Zero    = 1'b0;
    #12 Reset_n = 1'b1;
    #1;
    check("rst_state_d0", obs0, Zv);
    check("rst_state_d1", obs1, Zv);
    @(posedge Clk); #1;
    check("decode_d0", obs0, Zv);

    // R-type ALU ops: add, sub, sra
    run("add",  r_instr(6'b110000), 1'b0, 3, alu_add, wb_add, Zv);
    run("sub",  r_instr(6'b110001), 1'b1, 3, alu_sub, wb_sub, Zv);
    run("sra",  r_instr(6'b111000), 1'b0, 3, alu_sra, wb_sra, Zv);
    // I-type ALU ops
    run("addi", op_instr(6'b110000), 1'b0, 3, alu_lui, wb_lui, Zv);
    run("ori",  op_instr(6'b110011), 1'b0, 3, alu_ori, wb_ori, Zv);
    run("andi", op_instr(6'b110010), 1'b1, 3, alu_andi, wb_andi, Zv);
    run("lui",  op_instr(6'b111001), 1'b0, 3, alu_lui, wb_lui, Zv);
    // Loads and stores
    run("lw",   op_instr(6'b001111), 1'b0, 4, addr, addr, wb_mem);
    run("lb",   op_instr(6'b000011), 1'b1, 4, addr, addr, wb_mem);
    run("sw",   op_instr(6'b011111), 1'b0, 3, addr, mem_wr, Zv);
    run("sb",   op_instr(6'b000111), 1'b1, 3, addr, mem_wr, Zv);
    // Branches
    run("beq_z1", op_instr(6'b000000), 1'b1, 2, br_t, Zv, Zv);
    run("beq_z0", op_instr(6'b000000), 1'b0, 2, br_nt, Zv, Zv);
    run("bne_z1", op_instr(6'b000001), 1'b1, 2, br_nt, Zv, Zv);
    run("bne_z0", op_instr(6'b000001), 1'b0, 2, br_t, Zv, Zv);
    run("b_z0",   op_instr(6'b111111), 1'b0, 2, br_t, Zv, Zv);
    run("b_z1",   op_instr(6'b111111), 1'b1, 2, br_t, Zv, Zv);

    // Reset asserted mid-writeback must kill the write immediately
    Instr = r_instr(6'b110001);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    check("mid_wb_d0", obs0, wb_sub);
    Reset_n = 1'b0;
    #1;
    check("mid_rst_d0", obs0, Zv);
    check("mid_rst_d1", obs1, Zv);
    @(posedge Clk); #1;
    check("mid_rst_hold_d0", obs0, Zv);
    #2 Reset_n = 1'b1;
    @(posedge Clk); #1;
    run("post_rst_sub", r_instr(6'b110001), 1'b0, 3, alu_sub, wb_sub, Zv);

    // Illegal opcode: dut0 skips as NOP, dut1 traps
    Instr = op_instr(6'b101010);
    #1;
    check("ill_c1_d0", obs0, Zv);
    check("ill_c1_d1", obs1, Zv);
    @(posedge Clk); #1;
    check("ill_c2_d0", obs0, ev(0, 1, 0, 0, 0, 0, 4'b0000, 0, 1, 0));
    check("ill_c2_d1", obs1, ev(0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 1));
    @(posedge Clk); #1;
    // dut0 back in decode: run an add while dut1 stays halted
    Instr = r_instr(6'b110000);
    #1;
    check("ill_next_c1_d0", obs0, Zv);
    check("halt_hold1_d1", obs1, ev(0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 1));
    @(posedge Clk); #1;
    check("ill_next_c2_d0", obs0, alu_add);
    check("halt_hold2_d1", obs1, ev(0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 1));
    @(posedge Clk); #1;
    check("ill_next_c3_d0", obs0, wb_add);
    check("halt_hold3_d1", obs1, ev(0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 1));
    @(posedge Clk); #1;
    // Illegal R func on dut0
    Instr = r_instr(6'b000101);
    #1;
    check("rill_c1_d0", obs0, Zv);
    @(posedge Clk); #1;
    check("rill_c2_d0", obs0, ev(0, 1, 0, 0, 0, 0, 4'b0000, 0, 1, 0));
    check("halt_hold4_d1", obs1, ev(0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 1));

    // Reset releases the trap
    Reset_n = 1'b0;
    #1;
    check("trap_rst_d1", obs1, Zv);
    check("trap_rst_d0", obs0, Zv);
    @(posedge Clk); #3;
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    run("after_trap_lw", op_instr(6'b001111), 1'b0, 4, addr, addr, wb_mem);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound so the run always terminates
  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
